// File: rtl/mark_sprite_renderer_if.sv
// Signal bundle between the VGA scan logic, the mark sprite ROM and the
// pixel colour mux. There is no valid/ready handshake on this bus: every
// signal is sampled on each pixel clock. The renderer (slave) drives
// rom_row/rom_col combinationally from the current scan position, expects
// rom_data for that address one clock later, and presents mark_on/mark_rgb
// two clocks after the scan position that produced them. dbg_state and
// dbg_visible expose the show/blink/hide machine for observation only.
interface mark_sprite_renderer_if;
  logic        frame_tick;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        show_req;
  logic        hide_req;
  logic [4:0]  rom_row;
  logic [1:0]  rom_col;
  logic [11:0] rom_data;
  logic        mark_on;
  logic [11:0] mark_rgb;
  logic        busy;
  logic [1:0]  dbg_state;
  logic        dbg_visible;

  modport master (
    output frame_tick, video_on, pixel_x, pixel_y, pos_x, pos_y,
    output show_req, hide_req, rom_data,
    input  rom_row, rom_col, mark_on, mark_rgb, busy, dbg_state, dbg_visible
  );

  modport slave (
    input  frame_tick, video_on, pixel_x, pixel_y, pos_x, pos_y,
    input  show_req, hide_req, rom_data,
    output rom_row, rom_col, mark_on, mark_rgb, busy, dbg_state, dbg_visible
  );
endinterface

// File: rtl/mark_sprite_renderer.sv
// Mark sprite renderer: maps the VGA scan position onto sprite ROM
// addresses for a mark at a frame-latched position, aligns the returned
// colour with its pixel, applies transparency and a show/blink/hide
// visibility state machine.
module mark_sprite_renderer #(
  parameter int          W             = 4,
  parameter int          H             = 20,
  parameter logic [11:0] TRANSPARENT   = 12'h000,
  parameter int          BLINK_FRAMES  = 16,
  parameter int          BLINK_TOGGLES = 6
) (
  input  logic             clk,
  input  logic             reset,
  mark_sprite_renderer_if.slave bus
);

  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int TCW = $clog2(BLINK_TOGGLES + 1);

  typedef enum logic [1:0] {
    ST_HIDDEN = 2'd0,
    ST_BLINK  = 2'd1,
    ST_SHOWN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [TCW-1:0]   toggle_cnt_q, toggle_cnt_d;
  logic [TCW-1:0]   toggle_inc;
  logic             visible_q, visible_d;

  logic [9:0]       pos_x_q, pos_y_q;
  logic [10:0]      dx, dy;
  logic             hit;
  logic             hit_d1_q;
  logic             mark_on_d;
  logic             mark_on_q;
  logic [11:0]      mark_rgb_q;

  // Latch the requested position only at frame start so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x_q <= '0;
      pos_y_q <= '0;
    end else if (bus.frame_tick) begin
      pos_x_q <= bus.pos_x;
      pos_y_q <= bus.pos_y;
    end
  end

  // Hit decode: 11-bit unsigned offsets, so positions left/above the mark
  // wrap to large values and never hit (no wrap-around to the other edge).
  always_comb begin
    dx = {1'b0, bus.pixel_x} - {1'b0, pos_x_q};
    dy = {1'b0, bus.pixel_y} - {1'b0, pos_y_q};
    hit = bus.video_on && (dx < 11'(W)) && (dy < 11'(H));
    bus.rom_row = hit ? dy[4:0] : 5'd0;
    bus.rom_col = hit ? dx[1:0] : 2'd0;
  end

  // ROM colour for the previous cycle's address is on rom_data now.
  always_comb begin
    mark_on_d = hit_d1_q && visible_q && (bus.rom_data != TRANSPARENT);
  end

  // Two-stage pixel pipeline: hit delay, then registered colour output.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_d1_q   <= 1'b0;
      mark_on_q  <= 1'b0;
      mark_rgb_q <= '0;
    end else begin
      hit_d1_q   <= hit;
      mark_on_q  <= mark_on_d;
      mark_rgb_q <= mark_on_d ? bus.rom_data : 12'h000;
    end
  end

  // Visibility state machine registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_HIDDEN;
      frame_cnt_q  <= '0;
      toggle_cnt_q <= '0;
      visible_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      toggle_cnt_q <= toggle_cnt_d;
      visible_q    <= visible_d;
    end
  end

  // Next state: show (re)starts a blink, hide overrides everything; a
  // frame_tick on the entry cycle is deliberately not counted.
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    toggle_cnt_d = toggle_cnt_q;
    visible_d    = visible_q;
    toggle_inc   = toggle_cnt_q + 1'b1;

    case (state_q)
      ST_HIDDEN: begin
        visible_d = 1'b0;
        if (bus.show_req) begin
          state_d      = ST_BLINK;
          frame_cnt_d  = '0;
          toggle_cnt_d = '0;
          visible_d    = 1'b1;
        end
      end
      ST_BLINK: begin
        if (bus.show_req) begin
          frame_cnt_d  = '0;
          toggle_cnt_d = '0;
          visible_d    = 1'b1;
        end else if (bus.frame_tick) begin
          if (frame_cnt_q == FCW'(BLINK_FRAMES - 1)) begin
            frame_cnt_d  = '0;
            visible_d    = ~visible_q;
            toggle_cnt_d = toggle_inc;
            if (toggle_inc == TCW'(BLINK_TOGGLES)) begin
              state_d   = ST_SHOWN;
              visible_d = 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      ST_SHOWN: begin
        visible_d = 1'b1;
        if (bus.show_req) begin
          state_d      = ST_BLINK;
          frame_cnt_d  = '0;
          toggle_cnt_d = '0;
          visible_d    = 1'b1;
        end
      end
      default: begin
        state_d   = ST_HIDDEN;
        visible_d = 1'b0;
      end
    endcase

    if (bus.hide_req) begin
      state_d      = ST_HIDDEN;
      frame_cnt_d  = '0;
      toggle_cnt_d = '0;
      visible_d    = 1'b0;
    end
  end

  // Output drive.
  always_comb begin
    bus.mark_on     = mark_on_q;
    bus.mark_rgb    = mark_rgb_q;
    bus.busy        = (state_q == ST_BLINK);
    bus.dbg_state   = state_q;
    bus.dbg_visible = visible_q;
  end

endmodule

// File: tb/tb_mark_sprite_renderer.sv
// Bench for mark_sprite_renderer: directed scenarios followed by random
// scan/control traffic, all checked against a frame/tick-count model.
module tb_mark_sprite_renderer;

  localparam int          W      = 4;
  localparam int          H      = 20;
  localparam int          BF     = 2;
  localparam int          BT     = 2;
  localparam logic [11:0] TRANSP = 12'h000;

  logic clk;
  logic reset;
  mark_sprite_renderer_if bus();

  mark_sprite_renderer #(
    .W(W), .H(H), .TRANSPARENT(TRANSP),
    .BLINK_FRAMES(BF), .BLINK_TOGGLES(BT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [12:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: mode 0 hidden, 1 blinking, 2 shown
  logic [11:0] rom [0:31][0:3];
  int  m_mode, m_ticks, m_px, m_py;
  bit  pend_hit;
  int  pend_row, pend_col;

  function automatic bit m_vis();
    if (m_mode == 2) return 1'b1;
    if (m_mode == 1) return ((m_ticks / BF) % 2) == 0;
    return 1'b0;
  endfunction

  // driver: one pixel clock with the given inputs
  task automatic step(input bit rst, input bit ft, input bit vo,
                      input int px, input int py, input int posx, input int posy,
                      input bit sr, input bit hr);
    bit h, eon;
    int dx, dy;
    logic [11:0] d, ergb, nrom;
    logic [12:0] e;
    reset          = rst;
    bus.frame_tick = ft;
    bus.video_on   = vo;
    bus.pixel_x    = 10'(px);
    bus.pixel_y    = 10'(py);
    bus.pos_x      = 10'(posx);
    bus.pos_y      = 10'(posy);
    bus.show_req   = sr;
    bus.hide_req   = hr;
    #1;
    dx = px - m_px;
    dy = py - m_py;
    h  = vo && dx >= 0 && dx < W && dy >= 0 && dy < H;
    check_eq("rom_row", bus.rom_row, h ? dy : 0);
    check_eq("rom_col", bus.rom_col, h ? dx : 0);
    check_eq("busy", bus.busy, m_mode == 1);
    check_eq("visible", bus.dbg_visible, m_vis());
    d = 12'h000;
    eon = 1'b0;
    if (!rst && pend_hit) begin
      d   = rom[pend_row][pend_col];
      eon = m_vis() && (d != TRANSP);
    end
    ergb = eon ? d : 12'h000;
    exp_q.push_back({eon, ergb});
    nrom = rom[bus.rom_row][bus.rom_col];
    if (rst) begin
      m_mode = 0; m_ticks = 0; m_px = 0; m_py = 0;
    end else begin
      if (ft) begin m_px = posx; m_py = posy; end
      if (hr) m_mode = 0;
      else if (sr) begin m_mode = 1; m_ticks = 0; end
      else if (m_mode == 1 && ft) begin
        m_ticks++;
        if (m_ticks >= BF * BT) m_mode = 2;
      end
    end
    pend_hit = !rst && h;
    pend_row = dy;
    pend_col = dx;
    @(posedge clk);
    #1;
    bus.rom_data = nrom;
    e = exp_q.pop_front();
    check_eq("mark_on", bus.mark_on, e[12]);
    check_eq("mark_rgb", bus.mark_rgb, e[11:0]);
  endtask

  task automatic idle(input int n, input int posx, input int posy);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0, posx, posy, 0, 0);
  endtask

  initial begin
    int cpx, cpy, sel;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 4; c++)
        rom[r][c] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
    rom[0][0]  = 12'hF11;
    rom[19][3] = 12'hABC;
    for (int c = 0; c < 4; c++) rom[13][c] = 12'h000;

    reset = 1'b1;
    bus.frame_tick = 0; bus.video_on = 0; bus.pixel_x = 0; bus.pixel_y = 0;
    bus.pos_x = 0; bus.pos_y = 0; bus.show_req = 0; bus.hide_req = 0;
    bus.rom_data = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mark_on", bus.mark_on, 0);
    check_eq("rst_mark_rgb", bus.mark_rgb, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_visible", bus.dbg_visible, 0);
    m_mode = 0; m_ticks = 0; m_px = 0; m_py = 0; pend_hit = 0;

    // latch (100,50) and start blink on the same tick, then wait it out
    step(0, 1, 0, 0, 0, 100, 50, 1, 0);
    for (int i = 0; i < BF * BT + 2; i++) step(0, 1, 1, 0, 0, 100, 50, 0, 0);
    check_eq("shown_busy", bus.busy, 0);

    // top-left pixel, bottom-right corner and just past each edge
    step(0, 0, 1, 100, 50, 100, 50, 0, 0);
    idle(2, 100, 50);
    step(0, 0, 1, 103, 69, 100, 50, 0, 0);
    step(0, 0, 1, 104, 69, 100, 50, 0, 0);
    step(0, 0, 1, 103, 70, 100, 50, 0, 0);
    step(0, 0, 1, 100, 63, 100, 50, 0, 0);
    idle(2, 100, 50);

    // position change mid-frame only takes effect at the next tick
    step(0, 0, 1, 100, 50, 300, 50, 0, 0);
    step(0, 0, 1, 300, 50, 300, 50, 0, 0);
    step(0, 1, 1, 0, 0, 300, 50, 0, 0);
    step(0, 0, 1, 300, 50, 300, 50, 0, 0);
    step(0, 0, 1, 100, 50, 300, 50, 0, 0);
    idle(2, 300, 50);

    // blink from hidden while scanning a visible pixel
    step(0, 0, 1, 300, 50, 300, 50, 0, 1);
    step(0, 0, 1, 300, 50, 300, 50, 1, 0);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 1, 300, 50, 300, 50, 0, 0);
      step(0, 0, 1, 300, 50, 300, 50, 0, 0);
      step(0, 1, 1, 300, 50, 300, 50, 0, 0);
    end

    // show and hide together during blink: hide wins
    step(0, 0, 1, 300, 50, 300, 50, 1, 0);
    step(0, 1, 1, 300, 50, 300, 50, 0, 0);
    step(0, 0, 1, 300, 50, 300, 50, 1, 1);
    idle(2, 300, 50);

    // reset in the middle of a blink with pixels in flight
    step(0, 0, 1, 300, 50, 300, 50, 1, 0);
    step(0, 0, 1, 301, 51, 300, 50, 0, 0);
    step(0, 0, 1, 302, 52, 300, 50, 0, 0);
    step(1, 0, 1, 303, 53, 300, 50, 0, 0);
    idle(2, 300, 50);

    // partly off-screen mark must not wrap to x=0
    step(0, 1, 1, 0, 0, 638, 100, 1, 0);
    for (int i = 0; i < BF * BT + 2; i++) step(0, 1, 1, 0, 0, 638, 100, 0, 0);
    for (int x = 636; x < 644; x++) step(0, 0, 1, x, 100, 638, 100, 0, 0);
    for (int x = 0; x < 4; x++) step(0, 0, 1, x, 100, 638, 100, 0, 0);
    idle(2, 638, 100);

    // random traffic around the current position
    cpx = 638; cpy = 100;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        sel = $urandom_range(0, 3);
        cpx = (sel == 0) ? 638 : (sel == 1) ? 1022 : (sel == 2) ? 0 : $urandom_range(0, 1023);
        cpy = (sel == 1) ? 1015 : $urandom_range(0, 1023);
      end
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) != 0,
           (cpx + $urandom_range(0, 8) - 2) & 1023,
           (cpy + $urandom_range(0, 24) - 2) & 1023,
           cpx, cpy,
           $urandom_range(0, 63) == 0,
           $urandom_range(0, 127) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
